// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared grant type, default widths and response record for mem_responder.
package mem_responder_pkg;
  localparam int DEFWIDTH = 16;
  localparam int DEFINSTRUCTIONWIDTH = 24;
  localparam int DEFDEPTHBITS = 10;
  localparam int DEFSTARVELIMIT = 3;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_FETCH, GRANT_DATA} grant_t;
  typedef struct packed {
    logic valid;
    logic [DEFINSTRUCTIONWIDTH-1:0] data;
    logic error;
  } resp_t;
endpackage

// File: rtl/responder_arbiter.sv
// responder_arbiter: data-priority grant with a saturating fetch starvation guard.
module responder_arbiter
  import mem_responder_pkg::*;
#(
  parameter int STARVELIMIT = DEFSTARVELIMIT
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   fetchValid,
  input  logic   dataValid,
  output grant_t grant
);
  localparam int CW = $clog2(STARVELIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVELIMIT);
  logic [CW-1:0] starveCount;
  always_comb
    grant = (fetchValid && (!dataValid || starveCount >= LIMIT)) ? GRANT_FETCH :
            dataValid ? GRANT_DATA : GRANT_NONE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) starveCount <= '0;
    else if (!fetchValid || grant == GRANT_FETCH) starveCount <= '0;
    else if (starveCount < LIMIT) starveCount <= starveCount + 1'b1;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: two-port (fetch/data) responder over one single-port array, 1-cycle latency.
// Optional RESPONDER_RANGE_CHECK_EN flags addresses beyond the array instead of wrapping them.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WIDTH = DEFWIDTH,
  parameter int INSTRUCTIONWIDTH = DEFINSTRUCTIONWIDTH,
  parameter int DEPTHBITS = DEFDEPTHBITS,
  parameter int STARVELIMIT = DEFSTARVELIMIT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetchValid,
  output logic                        fetchReady,
  input  logic [WIDTH-1:0]            fetchAddress,
  output logic                        fetchRespValid,
  output logic [INSTRUCTIONWIDTH-1:0] fetchInstruction,
  input  logic                        dataValid,
  output logic                        dataReady,
  input  logic                        dataWriteEnable,
  input  logic [WIDTH-1:0]            dataAddress,
  input  logic [WIDTH-1:0]            dataWriteData,
  output logic                        dataRespValid,
  output logic [WIDTH-1:0]            dataReadData
`ifdef RESPONDER_RANGE_CHECK_EN
  ,
  output logic                        fetchError,
  output logic                        dataError
`endif
);
  grant_t grant;
  logic [INSTRUCTIONWIDTH-1:0] storage [1 << DEPTHBITS];
  logic [WIDTH-1:0] reqAddress;
  logic [DEPTHBITS-1:0] index;
  logic outOfRange;
  logic doWrite;
  responder_arbiter #(.STARVELIMIT(STARVELIMIT)) arbiter (
    .clock(clock),
    .reset(reset),
    .fetchValid(fetchValid),
    .dataValid(dataValid),
    .grant(grant)
  );
  assign fetchReady = grant == GRANT_FETCH;
  assign dataReady = grant == GRANT_DATA;
  assign reqAddress = fetchReady ? fetchAddress : dataAddress;
  assign index = reqAddress[DEPTHBITS-1:0];
`ifdef RESPONDER_RANGE_CHECK_EN
  assign outOfRange = |reqAddress[WIDTH-1:DEPTHBITS];
`else
  logic unusedUpper;
  assign unusedUpper = |reqAddress[WIDTH-1:DEPTHBITS];
  assign outOfRange = 1'b0;
`endif
  assign doWrite = dataReady && dataWriteEnable && !outOfRange;
  // Data writes touch only the low WIDTH bits; the instruction-only upper bits are preserved.
  always_ff @(posedge clock)
    if (doWrite) storage[index][WIDTH-1:0] <= dataWriteData;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      fetchRespValid <= 1'b0;
      dataRespValid <= 1'b0;
      fetchInstruction <= '0;
      dataReadData <= '0;
`ifdef RESPONDER_RANGE_CHECK_EN
      fetchError <= 1'b0;
      dataError <= 1'b0;
`endif
    end else begin
      fetchRespValid <= fetchReady;
      dataRespValid <= dataReady;
      if (fetchReady) fetchInstruction <= outOfRange ? '0 : storage[index];
      if (dataReady)
        dataReadData <= outOfRange ? '0 : dataWriteEnable ? dataWriteData : storage[index][WIDTH-1:0];
`ifdef RESPONDER_RANGE_CHECK_EN
      fetchError <= fetchReady && outOfRange;
      dataError <= dataReady && outOfRange;
`endif
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven directed checks of mem_responder plus reset and address-range sequences.
module tb_mem_responder;
  typedef struct {
    logic fv; logic [15:0] fa;
    logic dv; logic dwe; logic [15:0] da; logic [15:0] dwd;
    logic efr; logic edr;
    logic efv; logic [23:0] efi;
    logic edv; logic [15:0] edd;
    logic efe; logic ede;
  } vec_t;
`ifdef RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic fetchValid = 1'b0, dataValid = 1'b0, dataWriteEnable = 1'b0;
  logic [15:0] fetchAddress = '0, dataAddress = '0, dataWriteData = '0;
  logic fetchReady, dataReady, fetchRespValid, dataRespValid;
  logic [23:0] fetchInstruction;
  logic [15:0] dataReadData;
  logic fetchError, dataError;
  int checks = 0;
  int errors = 0;
  vec_t tbl[16];
  mem_responder dut (
    .clock(clock),
    .reset(reset),
    .fetchValid(fetchValid),
    .fetchReady(fetchReady),
    .fetchAddress(fetchAddress),
    .fetchRespValid(fetchRespValid),
    .fetchInstruction(fetchInstruction),
    .dataValid(dataValid),
    .dataReady(dataReady),
    .dataWriteEnable(dataWriteEnable),
    .dataAddress(dataAddress),
    .dataWriteData(dataWriteData),
    .dataRespValid(dataRespValid),
    .dataReadData(dataReadData)
`ifdef RESPONDER_RANGE_CHECK_EN
    ,
    .fetchError(fetchError),
    .dataError(dataError)
`endif
  );
`ifndef RESPONDER_RANGE_CHECK_EN
  assign fetchError = 1'b0;
  assign dataError = 1'b0;
`endif
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyVec(input vec_t v, input string tag);
    @(negedge clock);
    fetchValid = v.fv; fetchAddress = v.fa;
    dataValid = v.dv; dataWriteEnable = v.dwe; dataAddress = v.da; dataWriteData = v.dwd;
    #1;
    check({tag, " fetchReady"}, 32'(fetchReady), 32'(v.efr));
    check({tag, " dataReady"}, 32'(dataReady), 32'(v.edr));
    @(posedge clock);
    #1;
    check({tag, " fetchRespValid"}, 32'(fetchRespValid), 32'(v.efv));
    check({tag, " fetchInstruction"}, 32'(fetchInstruction), 32'(v.efi));
    check({tag, " dataRespValid"}, 32'(dataRespValid), 32'(v.edv));
    check({tag, " dataReadData"}, 32'(dataReadData), 32'(v.edd));
    if (RC) begin
      check({tag, " fetchError"}, 32'(fetchError), 32'(v.efe));
      check({tag, " dataError"}, 32'(dataError), 32'(v.ede));
    end
  endtask

  initial begin
    dut.storage[5] = 24'hABCDEF;
    dut.storage[7] = 24'h5A0000;
    dut.storage[8] = 24'h00BEEF;
    //          fv    fa       dv    dwe   da       dwd       efr   edr   efv   efi          edv   edd       efe   ede
    tbl[0]  = '{1'b1, 16'd5,  1'b0, 1'b0, 16'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 24'hABCDEF, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'd0,  1'b1, 1'b1, 16'd7,  16'h1234, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 1'b1, 16'h1234, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'd0,  1'b1, 1'b0, 16'd7,  16'h0000, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 1'b1, 16'h1234, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'd7,  1'b0, 1'b0, 16'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 24'h5A1234, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 16'd0,  1'b0, 1'b0, 16'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 24'h5A1234, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'd7,  1'b1, 1'b1, 16'd7,  16'hCAFE, 1'b0, 1'b1, 1'b0, 24'h5A1234, 1'b1, 16'hCAFE, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'd7,  1'b0, 1'b0, 16'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 24'h5ACAFE, 1'b0, 16'hCAFE, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'd0,  1'b0, 1'b0, 16'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 24'h5ACAFE, 1'b0, 16'hCAFE, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'd5,  1'b1, 1'b0, 16'd8,  16'h0000, 1'b0, 1'b1, 1'b0, 24'h5ACAFE, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'd5,  1'b1, 1'b0, 16'd8,  16'h0000, 1'b0, 1'b1, 1'b0, 24'h5ACAFE, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'd5,  1'b1, 1'b0, 16'd8,  16'h0000, 1'b0, 1'b1, 1'b0, 24'h5ACAFE, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 16'd5,  1'b1, 1'b0, 16'd8,  16'h0000, 1'b1, 1'b0, 1'b1, 24'hABCDEF, 1'b0, 16'hBEEF, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 16'd5,  1'b1, 1'b0, 16'd7,  16'h0000, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 1'b1, 16'hCAFE, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 16'd5,  1'b1, 1'b0, 16'd8,  16'h0000, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 16'd0,  1'b0, 1'b0, 16'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 1'b0, 16'hBEEF, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 16'd5,  1'b1, 1'b0, 16'd8,  16'h0000, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 1'b1, 16'hBEEF, 1'b0, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    check("reset fetchRespValid", 32'(fetchRespValid), 32'd0);
    check("reset dataRespValid", 32'(dataRespValid), 32'd0);
    check("reset fetchInstruction", 32'(fetchInstruction), 32'd0);
    check("reset dataReadData", 32'(dataReadData), 32'd0);
    check("reset starveCount", 32'(dut.arbiter.starveCount), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) applyVec(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted one cycle after an accepted read, with fetch being refused.
    @(negedge clock);
    fetchValid = 1'b1; fetchAddress = 16'd5;
    dataValid = 1'b1; dataWriteEnable = 1'b0; dataAddress = 16'd8;
    @(posedge clock);
    #1;
    check("pre-reset dataRespValid", 32'(dataRespValid), 32'd1);
    check("pre-reset starveCount", 32'(dut.arbiter.starveCount), 32'd2);
    #1;
    reset = 1'b0;
    #1;
    check("async dataRespValid", 32'(dataRespValid), 32'd0);
    check("async dataReadData", 32'(dataReadData), 32'd0);
    check("async fetchInstruction", 32'(fetchInstruction), 32'd0);
    check("async starveCount", 32'(dut.arbiter.starveCount), 32'd0);
    @(negedge clock);
    fetchValid = 1'b0; dataValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("post-reset fetchRespValid%0d", i), 32'(fetchRespValid), 32'd0);
      check($sformatf("post-reset dataRespValid%0d", i), 32'(dataRespValid), 32'd0);
    end

    // Addresses beyond the array: wrap by default, flagged when range checking is built in.
    dut.storage[5] = 24'h000111;
    applyVec('{1'b1, 16'h0405, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0,
               1'b1, RC ? 24'h0 : 24'h000111, 1'b0, 16'h0000, RC, 1'b0}, "wrapFetch");
    applyVec('{1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0,
               1'b0, RC ? 24'h0 : 24'h000111, 1'b0, 16'h0000, 1'b0, 1'b0}, "wrapIdle");
    applyVec('{1'b0, 16'd0, 1'b1, 1'b1, 16'h0407, 16'h7777, 1'b0, 1'b1,
               1'b0, RC ? 24'h0 : 24'h000111, 1'b1, RC ? 16'h0 : 16'h7777, 1'b0, RC}, "wrapWrite");
    applyVec('{1'b1, 16'd7, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0,
               1'b1, RC ? 24'h5ACAFE : 24'h5A7777, 1'b0, RC ? 16'h0 : 16'h7777, 1'b0, 1'b0}, "wrapCheck");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the pipelined CPU. It serves two request ports, instruction fetch (read-only) and data (read/write), from one unified single-port storage array.
- Valid/ready request handshake per port; fixed one-cycle response latency.
- Arbitrates between the ports with data priority and a fetch starvation guard.
- Exposes fetch back-pressure that the CPU's hazard logic uses as a stall.

Parameters:
- WIDTH, 16, data word and address width.
- INSTRUCTIONWIDTH, 24, storage word width; data accesses use bits [WIDTH-1:0].
- DEPTHBITS, 10, log2 of storage depth (1024 words).
- STARVELIMIT, 3, consecutive cycles fetch may be refused before it wins priority.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetchValid  input  1  fetch request present.
- fetchReady  output  1  fetch request accepted this cycle.
- fetchAddress  input  WIDTH  fetch word address.
- fetchRespValid  output  1  fetchInstruction valid.
- fetchInstruction  output  INSTRUCTIONWIDTH  fetched word.
- dataValid  input  1  data request present.
- dataReady  output  1  data request accepted this cycle.
- dataWriteEnable  input  1  1 = write, 0 = read.
- dataAddress  input  WIDTH  data word address.
- dataWriteData  input  WIDTH  write payload.
- dataRespValid  output  1  data response valid.
- dataReadData  output  WIDTH  read result, or echoed write data.
- fetchError, dataError  output  1 each  only with RESPONDER_RANGE_CHECK_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every output register clears to 0: resp valids, fetchInstruction, dataReadData, error flags.
  - The starvation counter clears to 0.
  - Storage contents are not reset.
  - A response pending when reset asserts is dropped and never emitted.
- Grant (combinational, at most one per cycle):
  - Only fetchValid: GRANT_FETCH.
  - Only dataValid: GRANT_DATA.
  - Both, starveCount < STARVELIMIT: GRANT_DATA.
  - Both, starveCount >= STARVELIMIT: GRANT_FETCH.
  - Neither: GRANT_NONE.
  - fetchReady = (grant==GRANT_FETCH); dataReady = (grant==GRANT_DATA).
  - Ready may depend combinationally on both valids.
- Starvation counter:
  - Increments (saturating at STARVELIMIT) each cycle fetchValid=1 and fetchReady=0.
  - Clears on any fetch grant, or on any cycle with fetchValid=0.
- Accepted read: at the granting edge the storage word at address[DEPTHBITS-1:0] is registered. The next cycle, respValid=1 with that word.
- Accepted write:
  - At the granting edge, storage[address][WIDTH-1:0] = dataWriteData; bits [INSTRUCTIONWIDTH-1:WIDTH] are preserved.
  - The next cycle, dataRespValid=1 and dataReadData = written value.
- Throughput and latency:
  - Back-to-back accepts are allowed: one per cycle, responses in order, exactly 1-cycle latency.
  - There is no response back-pressure; the requester must capture the response in the valid cycle.
- Response data hold: fetchInstruction and dataReadData hold their last value when respValid=0.
- Read-after-write:
  - A data write at cycle t followed by any read of the same address at t+1 returns the new value.
  - The fetch path sees only bits [WIDTH-1:0] updated.
- Address handling: without the feature, upper address bits above DEPTHBITS are ignored, so addresses wrap.
- Request stability: requests must hold address, data and write enable stable while valid=1 and ready=0. The block does not check this.

Optional Feature:
- Macro: RESPONDER_RANGE_CHECK_EN.
- Defined:
  - An accepted request with any address bit [WIDTH-1:DEPTHBITS] set is still handshaked and still produces respValid the next cycle.
  - Its response data is 0 and the corresponding error flag is 1 for that response cycle only.
  - An out-of-range write does not modify storage.
- Undefined: fetchError and dataError are absent; addresses wrap as described above.

Decomposition:
- Package mem_responder_pkg:
  - grant_t enum {GRANT_NONE, GRANT_FETCH, GRANT_DATA}.
  - Default width constants.
  - Response struct {valid, data, error}.
- Sub-module responder_arbiter:
  - Contains the grant logic and the saturating starvation counter.
  - Inputs: clock, reset, fetchValid, dataValid.
  - Output: grant.
- Storage array, response registers and range check stay in the top level.

Test Plan:
- Preload storage[5]=24'hABCDEF; fetchValid=1, fetchAddress=5 -> fetchReady=1 same cycle; next cycle fetchRespValid=1, fetchInstruction=24'hABCDEF.
- Data write address 7, value 16'h1234; then data read address 7 the following cycle -> write resp dataReadData=16'h1234; next cycle read resp dataReadData=16'h1234; storage[7][23:16] unchanged.
- fetchValid and dataValid held high for 6 cycles, STARVELIMIT=3 -> grants D,D,D,F,D,D; fetchReady first asserts in cycle 4; starveCount returns to 0 after that grant.
- Reset asserted low mid-stream, one cycle after an accepted read -> responses and counter are 0 immediately (asynchronously); no response emitted after release.
- Without the feature, fetchAddress=16'h0405 with storage[5]=24'h000111 -> fetchInstruction=24'h000111 (wrap).
- With RESPONDER_RANGE_CHECK_EN: the same request -> response data 0, fetchError=1 for one cycle. A write to 16'h0407 -> dataError=1 and storage[7] unchanged.
